thermocouple_spi_responder: RTL and testbench

- Behavioural/synthesizable model of the thermocouple-to-digital converter that sits on the far end of the thermocouple SPI link.
- Periodically "converts" by latching the supplied temperature and fault values into a 32-bit frame.
- Shifts that frame out MSB-first on miso while the master holds cs_n low.
- Used as the sensor-side stimulus for the thermocouple reader and its SPI master, and as an FPGA-resident sensor emulator.

---
 rtl/thermocouple_pkg.sv | 34 +++
 rtl/thermocouple_spi_responder_if.sv | 23 ++
 rtl/spi_sync_edge.sv | 29 ++
 rtl/thermocouple_spi_responder.sv | 123 ++++++++++++
 tb/tb_thermocouple_spi_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/thermocouple_pkg.sv
// Frame layout, FSM state encoding and frame builder shared by the thermocouple responder.
package thermocouple_pkg;

   localparam int FRAME_BITS  = 32;
   localparam int TC_MSB      = 31;
   localparam int TC_LSB      = 18;
   localparam int FLT_ANY_BIT = 16;
   localparam int JT_MSB      = 15;
   localparam int JT_LSB      = 4;
   localparam int FLT_MSB     = 2;
   localparam int FLT_LSB     = 0;

   typedef enum logic [1:0] {
      CONVERT,
      READY,
      SHIFT
   } state_e;

   // Bits 17 and 3 are reserved and always read as zero.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [TC_MSB-TC_LSB:0]   tc,
      input logic [JT_MSB-JT_LSB:0]   jt,
      input logic [FLT_MSB-FLT_LSB:0] fault
   );
      logic [FRAME_BITS-1:0] f;
      f                  = '0;
      f[TC_MSB:TC_LSB]   = tc;
      f[FLT_ANY_BIT]     = |fault;
      f[JT_MSB:JT_LSB]   = jt;
      f[FLT_MSB:FLT_LSB] = fault;
      return f;
   endfunction

endpackage

// File: rtl/thermocouple_spi_responder_if.sv
// SPI pins between the thermocouple reader (master) and the sensor-side responder (slave).
interface thermocouple_spi_responder_if;

   logic sclk;
   logic cs_n;
   logic miso;
   logic miso_oe;

   modport master (
      output sclk,
      output cs_n,
      input  miso,
      input  miso_oe
   );

   modport slave (
      input  sclk,
      input  cs_n,
      output miso,
      output miso_oe
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a registered edge detector; rise/fall pulse
// for one clk cycle, two cycles after the pin change is first sampled.
module spi_sync_edge (
   input  logic clk,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync2_q, prev_q;
   logic sync1_d, sync2_d, prev_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Left unreset on purpose: a cs_n held low across reset must not look like a fresh fall.
   always_ff @(posedge clk) begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
   end

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

endmodule

// File: rtl/thermocouple_spi_responder.sv
// Thermocouple converter emulator: periodically samples temp/fault into a 32-bit frame
// and shifts it out MSB-first on miso while cs_n is low; pin-to-action latency 3 clk.
module thermocouple_spi_responder
   import thermocouple_pkg::*;
#(
   parameter int CONV_CYCLES = 400,
   parameter int CBITS       = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   thermocouple_spi_responder_if.slave  spi,
   input  logic [13:0]                  tc_temp_in,
   input  logic [11:0]                  junction_temp_in,
   input  logic [2:0]                   fault_in,
   output logic                         conv_busy,
   output logic [7:0]                   frames_sent
);

   logic sclk_fall, unused_sclk_rise, cs_rise, cs_fall;

   spi_sync_edge u_sclk_sync (.clk(clk), .din(spi.sclk), .rise(unused_sclk_rise), .fall(sclk_fall));
   spi_sync_edge u_cs_sync   (.clk(clk), .din(spi.cs_n), .rise(cs_rise),          .fall(cs_fall));

   state_e                state_q,    state_d;
   logic [CBITS-1:0]      conv_cnt_q, conv_cnt_d;
   logic [5:0]            bit_cnt_q,  bit_cnt_d;
   logic [FRAME_BITS-1:0] sample_q,   sample_d;
   logic [FRAME_BITS-1:0] shift_q,    shift_d;
   logic                  miso_q,     miso_d;
   logic                  miso_oe_q,  miso_oe_d;
   logic [7:0]            frames_q,   frames_d;

   logic                  conv_done;
   logic [FRAME_BITS-1:0] new_frame;
   logic [FRAME_BITS-1:0] load_frame;

   assign conv_done  = (state_q == CONVERT) && (conv_cnt_q == CBITS'(CONV_CYCLES - 1));
   assign new_frame  = build_frame(tc_temp_in, junction_temp_in, fault_in);
   assign load_frame = conv_done ? new_frame : sample_q;

   always_comb begin
      state_d    = state_q;
      conv_cnt_d = conv_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      sample_d   = sample_q;
      shift_d    = shift_q;
      miso_d     = miso_q;
      miso_oe_d  = miso_oe_q;
      frames_d   = frames_q;

      if (cs_rise) begin
         // Release wins over a coincident sclk fall; a partial frame is simply dropped.
         miso_d     = 1'b0;
         miso_oe_d  = 1'b0;
         conv_cnt_d = '0;
         state_d    = CONVERT;
      end else if (cs_fall) begin
         if (conv_done) sample_d = new_frame;
         shift_d    = load_frame;
         bit_cnt_d  = '0;
         miso_d     = load_frame[FRAME_BITS-1];
         miso_oe_d  = 1'b1;
         conv_cnt_d = '0;
         state_d    = SHIFT;
      end else begin
         case (state_q)
            CONVERT: begin
               conv_cnt_d = conv_cnt_q + 1'b1;
               if (conv_done) begin
                  sample_d   = new_frame;
                  conv_cnt_d = '0;
                  state_d    = READY;
               end
            end
            READY: ;
            SHIFT: begin
               if (sclk_fall) begin
                  if (bit_cnt_q < 6'd32) begin
                     shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 6'd1;
                     miso_d    = shift_q[FRAME_BITS-2];
                     if (bit_cnt_q == 6'd31) begin
                        miso_d   = 1'b0;
                        frames_d = frames_q + 8'd1;
                     end
                  end else begin
                     miso_d = 1'b0;
                  end
               end
            end
            default: state_d = CONVERT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CONVERT;
         conv_cnt_q <= '0;
         bit_cnt_q  <= '0;
         sample_q   <= '0;
         shift_q    <= '0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         frames_q   <= '0;
      end else begin
         state_q    <= state_d;
         conv_cnt_q <= conv_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sample_q   <= sample_d;
         shift_q    <= shift_d;
         miso_q     <= miso_d;
         miso_oe_q  <= miso_oe_d;
         frames_q   <= frames_d;
      end
   end

   assign spi.miso    = miso_q;
   assign spi.miso_oe = miso_oe_q;
   assign conv_busy   = (state_q == CONVERT);
   assign frames_sent = frames_q;

endmodule

// File: tb/tb_thermocouple_spi_responder.sv
// Directed bench for the thermocouple SPI responder, acting as the SPI master.
module tb_thermocouple_spi_responder;

   localparam int HALF = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [13:0] tc_temp_in;
   logic [11:0] junction_temp_in;
   logic [2:0]  fault_in;
   logic        conv_busy;
   logic [7:0]  frames_sent;

   thermocouple_spi_responder_if spi_if ();

   thermocouple_spi_responder dut (
      .clk              (clk),
      .rst              (rst),
      .spi              (spi_if),
      .tc_temp_in       (tc_temp_in),
      .junction_temp_in (junction_temp_in),
      .fault_in         (fault_in),
      .conv_busy        (conv_busy),
      .frames_sent      (frames_sent)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb_q[$];
   logic [31:0] rx;
   logic [31:0] full;

   function automatic logic [31:0] model_frame(input logic [13:0] tc, input logic [11:0] jt,
                                               input logic [2:0] f);
      return {tc, 1'b0, |f, jt, 1'b0, f};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      spi_if.cs_n = 1'b0;
      wait_cyc(4);
   endtask

   task automatic cs_high();
      spi_if.cs_n = 1'b1;
      wait_cyc(4);
   endtask

   // miso is captured at the moment sclk is driven high, as a real master samples on the rise.
   task automatic clock_bits(input int n, output logic [31:0] data);
      data = '0;
      for (int i = 0; i < n; i++) begin
         data        = {data[30:0], spi_if.miso};
         spi_if.sclk = 1'b1;
         wait_cyc(HALF);
         spi_if.sclk = 1'b0;
         wait_cyc(HALF);
      end
   endtask

   task automatic read_frame(input string tag);
      logic [31:0] d;
      cs_low();
      clock_bits(32, d);
      check(tag, d, sb_q.pop_front());
   endtask

   initial begin
      rst              = 1'b1;
      spi_if.cs_n      = 1'b1;
      spi_if.sclk      = 1'b0;
      tc_temp_in       = 14'h190;
      junction_temp_in = 12'h190;
      fault_in         = 3'b000;
      wait_cyc(5);
      check("rst_miso",   32'(spi_if.miso),    32'd0);
      check("rst_oe",     32'(spi_if.miso_oe), 32'd0);
      check("rst_busy",   32'(conv_busy),      32'd1);
      check("rst_frames", 32'(frames_sent),    32'd0);
      rst = 1'b0;

      // Nominal frame
      wait_cyc(10);
      check("busy_converting", 32'(conv_busy), 32'd1);
      wait_cyc(400);
      check("ready_after_conv", 32'(conv_busy), 32'd0);
      sb_q.push_back(model_frame(tc_temp_in, junction_temp_in, fault_in));
      read_frame("nominal_frame");
      check("nominal_frames", 32'(frames_sent),    32'd1);
      check("nominal_tail",   32'(spi_if.miso),    32'd0);
      check("nominal_oe",     32'(spi_if.miso_oe), 32'd1);
      cs_high();
      check("nominal_busy_release", 32'(conv_busy),      32'd1);
      check("nominal_oe_release",   32'(spi_if.miso_oe), 32'd0);

      // Fault frame
      fault_in = 3'b001;
      wait_cyc(410);
      sb_q.push_back(model_frame(tc_temp_in, junction_temp_in, fault_in));
      cs_low();
      clock_bits(32, rx);
      check("fault_frame",  rx, sb_q.pop_front());
      check("fault_bit16",  32'(rx[16]), 32'd1);
      check("fault_frames", 32'(frames_sent), 32'd2);
      cs_high();

      // Negative temperatures
      tc_temp_in       = 14'h3FF0;
      junction_temp_in = 12'hFF0;
      fault_in         = 3'b000;
      wait_cyc(410);
      sb_q.push_back(model_frame(tc_temp_in, junction_temp_in, fault_in));
      read_frame("negative_frame");
      check("negative_frames", 32'(frames_sent), 32'd3);
      cs_high();

      // Read during the first conversion after reset returns the cleared sample
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      check("rerst_frames", 32'(frames_sent), 32'd0);
      wait_cyc(100);
      check("early_busy", 32'(conv_busy), 32'd1);
      sb_q.push_back(32'h0);
      read_frame("early_frame");
      check("early_frames", 32'(frames_sent), 32'd1);
      cs_high();
      check("early_busy_release", 32'(conv_busy), 32'd1);
      wait_cyc(390);
      check("early_still_busy", 32'(conv_busy), 32'd1);
      wait_cyc(12);
      check("early_conv_done", 32'(conv_busy), 32'd0);

      // Aborted read after 10 bits
      full = model_frame(tc_temp_in, junction_temp_in, fault_in);
      sb_q.push_back(full >> 22);
      cs_low();
      clock_bits(10, rx);
      check("abort_partial", rx, sb_q.pop_front());
      spi_if.cs_n = 1'b1;
      wait_cyc(3);
      check("abort_oe",     32'(spi_if.miso_oe), 32'd0);
      check("abort_frames", 32'(frames_sent),    32'd1);
      wait_cyc(410);
      sb_q.push_back(full);
      read_frame("after_abort_frame");
      check("after_abort_frames", 32'(frames_sent), 32'd2);
      cs_high();

      // Reset in the middle of a frame, cs_n held low throughout
      wait_cyc(410);
      sb_q.push_back(full >> 16);
      cs_low();
      clock_bits(16, rx);
      check("midrst_partial", rx, sb_q.pop_front());
      rst = 1'b1;
      wait_cyc(1);
      check("midrst_miso",   32'(spi_if.miso),    32'd0);
      check("midrst_oe",     32'(spi_if.miso_oe), 32'd0);
      check("midrst_frames", 32'(frames_sent),    32'd0);
      check("midrst_busy",   32'(conv_busy),      32'd1);
      rst = 1'b0;
      clock_bits(8, rx);
      check("midrst_ignored_bits", rx,                  32'd0);
      check("midrst_ignored_oe",   32'(spi_if.miso_oe), 32'd0);
      cs_high();
      wait_cyc(410);
      sb_q.push_back(full);
      read_frame("post_rst_frame");
      check("post_rst_frames", 32'(frames_sent), 32'd1);
      cs_high();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
